// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: receives 11-bit PS/2 device-to-host frames and strobes valid or error per frame
module ps2_frame_receiver #(
    parameter int CLOCK_FREQUENCY = 25000000,
    parameter int TIMEOUT_CYCLES  = CLOCK_FREQUENCY / 5000
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] received_data,
    output logic       received_valid,
    output logic       parity_error,
    output logic       frame_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    logic          clk_meta_q, clk_sync_q, clk_prev_q, dat_meta_q, dat_sync_q;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic          fall, tmo_hit, timeout;
    assign fall           = clk_prev_q & ~clk_sync_q;
    assign tmo_hit        = tmo_q == TW'(TIMEOUT_CYCLES);
    assign timeout        = (state_q != IDLE) & tmo_hit & ~fall;
    assign received_data  = data_q;
    assign received_valid = valid_q;
    assign parity_error   = perr_q;
    assign frame_error    = ferr_q;
    // Two-flop synchronizers plus a delayed copy of the clock for edge detection; idle bus is high
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= PS2_CLK;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= PS2_DAT;
            dat_sync_q <= dat_meta_q;
        end
    end
    // Frame FSM: next state, shift/parity capture, timeout counter and output strobes
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        tmo_d     = (fall || state_q == IDLE) ? '0 : (tmo_hit ? tmo_q : tmo_q + TW'(1));
        case (state_q)
            IDLE: begin
                if (fall && !dat_sync_q) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = dat_sync_q;
                    state_d = STOP;
                end
            end
            default: begin
                if (fall) begin
                    state_d = IDLE;
                    ferr_d  = ~dat_sync_q;
                    valid_d = dat_sync_q & (^{shift_q, par_q});
                    perr_d  = dat_sync_q & ~(^{shift_q, par_q});
                    data_d  = valid_d ? shift_q : data_q;
                end
            end
        endcase
        if (timeout) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            ferr_d    = 1'b1;
        end
    end
    // State and output registers
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end
endmodule
